// File: rtl/multi_tap_draft_pkg.sv
// Shared definitions for the multi-tap draft controller.
//   tap_state_e : per-tap state code as shown on state_display
//   POUR_MAX    : saturation value of the global pour counter
//   cnt_w()     : width of a counter that must hold 0..n-1 (at least 1 bit)
package multi_tap_draft_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_FOAM = 2'd1,
    ST_BEER = 2'd2,
    ST_DONE = 2'd3
  } tap_state_e;

  localparam int          POUR_CNT_W = 16;
  localparam logic [15:0] POUR_MAX   = 16'hFFFF;

  // A counter that only ever reaches n-1 needs clog2(n) bits; n=1 still
  // gets a single bit so the register exists.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draft_tap_fsm.sv
// One tap channel: OFF -> FOAM -> BEER -> DONE state machine with its foam
// timeout counter, pour-step counter and sticky fault flag.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   step_i        one-cycle step strobe; state moves only when high
//   draft_i       draft lever of this tap
//   level_i       beer level of this tap
//   grant_i       arbiter grant to enter BEER on this step
//   state_o       current state code
//   req_o         tap is in FOAM and would enter BEER if granted
//   stay_beer_o   tap is in BEER and remains there on a step
//   pour_done_o   this step completes a pour (BEER -> DONE)
//   fault_o       sticky foam-timeout flag
module draft_tap_fsm
  import multi_tap_draft_pkg::*;
#(
  parameter int LEVEL_W      = 2,
  parameter int BEER_LEVEL   = 2,
  parameter int FOAM_TIMEOUT = 4,
  parameter int POUR_STEPS   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_i,
  input  logic               draft_i,
  input  logic [LEVEL_W-1:0] level_i,
  input  logic               grant_i,
  output logic [1:0]         state_o,
  output logic               req_o,
  output logic               stay_beer_o,
  output logic               pour_done_o,
  output logic               fault_o
);

  localparam int                 FW        = cnt_w(FOAM_TIMEOUT);
  localparam int                 PW        = cnt_w(POUR_STEPS);
  localparam logic [FW-1:0]      FOAM_LAST = FW'(FOAM_TIMEOUT - 1);
  localparam logic [PW-1:0]      POUR_LAST = PW'(POUR_STEPS - 1);
  localparam logic [LEVEL_W-1:0] LVL_BEER  = LEVEL_W'(BEER_LEVEL);

  tap_state_e    state_q;
  logic [FW-1:0] foam_cnt_q;
  logic [PW-1:0] pour_cnt_q;
  logic          fault_q;

  logic lvl_zero;
  logic lvl_beer;
  logic beer_ok;

  assign lvl_zero = (level_i == '0);
  // Level zero always wins over a BEER_LEVEL match, so a zero BEER_LEVEL
  // can never hold a tap in BEER.
  assign lvl_beer = !lvl_zero && (level_i == LVL_BEER);
  assign beer_ok  = draft_i && lvl_beer;

  // Arbiter-facing status, evaluated every cycle; only meaningful on a step.
  assign req_o       = (state_q == ST_FOAM) && beer_ok;
  assign stay_beer_o = (state_q == ST_BEER) && beer_ok && (pour_cnt_q != POUR_LAST);
  assign pour_done_o = step_i && (state_q == ST_BEER) && beer_ok && (pour_cnt_q == POUR_LAST);

  assign state_o = state_q;
  assign fault_o = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_OFF;
      foam_cnt_q <= '0;
      pour_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else if (step_i) begin
      case (state_q)
        ST_OFF: begin
          if (draft_i && !lvl_zero) begin
            state_q    <= ST_FOAM;
            foam_cnt_q <= '0;
          end
        end
        ST_FOAM: begin
          if (!draft_i || lvl_zero) begin
            state_q <= ST_OFF;
          end else if (lvl_beer && grant_i) begin
            state_q    <= ST_BEER;
            pour_cnt_q <= '0;
          end else if (foam_cnt_q == FOAM_LAST) begin
            // A denied tap still ages toward the timeout.
            state_q <= ST_OFF;
            fault_q <= 1'b1;
          end else begin
            foam_cnt_q <= foam_cnt_q + 1'b1;
          end
        end
        ST_BEER: begin
          if (lvl_zero) begin
            state_q <= ST_OFF;
          end else if (!beer_ok) begin
            state_q    <= ST_FOAM;
            foam_cnt_q <= '0;
          end else if (pour_cnt_q == POUR_LAST) begin
            state_q <= ST_DONE;
          end else begin
            pour_cnt_q <= pour_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (!draft_i) state_q <= ST_OFF;
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

endmodule

// File: rtl/multi_tap_draft.sv
// Multi-tap draft controller top: steps all taps on a rising edge of next,
// limits how many taps pour at once and counts completed pours.
// Ports:
//   clk, reset     clock, synchronous active-high reset (wins over a step)
//   next           step request, rising edge starts one step
//   draft          per-tap draft levers
//   beer_level     per-tap levels, tap i at [i*LEVEL_W +: LEVEL_W]
//   beer, done     per-tap state decodes
//   state_display  per-tap 2-bit state codes, tap i at [2*i +: 2]
//   fault          per-tap sticky foam-timeout flags
//   pour_count     saturating count of completed pours over all taps
module multi_tap_draft
  import multi_tap_draft_pkg::*;
#(
  parameter int N_TAPS       = 4,
  parameter int LEVEL_W      = 2,
  parameter int BEER_LEVEL   = 2,
  parameter int FOAM_TIMEOUT = 4,
  parameter int POUR_STEPS   = 3,
  parameter int MAX_ACTIVE   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      next,
  input  logic [N_TAPS-1:0]         draft,
  input  logic [N_TAPS*LEVEL_W-1:0] beer_level,
  output logic [N_TAPS-1:0]         beer,
  output logic [2*N_TAPS-1:0]       state_display,
  output logic [N_TAPS-1:0]         done,
  output logic [N_TAPS-1:0]         fault,
  output logic [15:0]               pour_count
);

  logic                  prev_next_q;
  logic                  step;
  logic [N_TAPS-1:0]     req;
  logic [N_TAPS-1:0]     stay_beer;
  logic [N_TAPS-1:0]     pour_done;
  logic [N_TAPS-1:0]     grant;
  logic [POUR_CNT_W-1:0] pour_count_q;
  logic [3:0]            done_sum;
  logic [POUR_CNT_W:0]   pc_sum;
  int                    avail;

  // prev_next clears in reset, so next held through release yields one
  // step on the first free cycle.
  always_ff @(posedge clk) begin
    if (reset) prev_next_q <= 1'b0;
    else       prev_next_q <= next;
  end

  assign step = next && !prev_next_q;

  // Slots left this step are whatever the taps staying in BEER leave free;
  // FOAM requesters take them lowest index first.
  always_comb begin
    avail = MAX_ACTIVE;
    for (int i = 0; i < N_TAPS; i++) begin
      if (stay_beer[i]) avail = avail - 1;
    end
    grant = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (req[i] && (avail > 0)) begin
        grant[i] = 1'b1;
        avail    = avail - 1;
      end
    end
  end

  for (genvar g = 0; g < N_TAPS; g++) begin : g_tap
    logic [1:0] st;

    draft_tap_fsm #(
      .LEVEL_W     (LEVEL_W),
      .BEER_LEVEL  (BEER_LEVEL),
      .FOAM_TIMEOUT(FOAM_TIMEOUT),
      .POUR_STEPS  (POUR_STEPS)
    ) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .step_i     (step),
      .draft_i    (draft[g]),
      .level_i    (beer_level[g*LEVEL_W +: LEVEL_W]),
      .grant_i    (grant[g]),
      .state_o    (st),
      .req_o      (req[g]),
      .stay_beer_o(stay_beer[g]),
      .pour_done_o(pour_done[g]),
      .fault_o    (fault[g])
    );

    assign state_display[2*g +: 2] = st;
    assign beer[g]                 = (st == ST_BEER);
    assign done[g]                 = (st == ST_DONE);
  end

  // Several taps may finish on one step; add them all, then clip.
  always_comb begin
    done_sum = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      done_sum = done_sum + 4'(pour_done[i]);
    end
    pc_sum = {1'b0, pour_count_q} + 17'(done_sum);
  end

  always_ff @(posedge clk) begin
    if (reset)          pour_count_q <= '0;
    else if (pc_sum[16]) pour_count_q <= POUR_MAX;
    else                 pour_count_q <= pc_sum[15:0];
  end

  assign pour_count = pour_count_q;

endmodule

// File: tb/tb_multi_tap_draft.sv
module tb_multi_tap_draft;

  localparam int N  = 4;
  localparam int LW = 2;
  localparam int SN = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              next = 1'b0;
  logic [N-1:0]      draft = '0;
  logic [N*LW-1:0]   beer_level = '0;
  logic [N-1:0]      beer, done, fault;
  logic [2*N-1:0]    state_display;
  logic [15:0]       pour_count;

  // Second instance sized for fast pouring, used to reach saturation.
  logic              s_next = 1'b0;
  logic [SN-1:0]     s_draft = '0;
  logic [SN*LW-1:0]  s_level = {SN{2'b10}};
  logic [SN-1:0]     s_beer, s_done, s_fault;
  logic [2*SN-1:0]   s_sd;
  logic [15:0]       s_pc;

  logic probe = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  multi_tap_draft dut (
    .clk(clk), .reset(reset), .next(next), .draft(draft), .beer_level(beer_level),
    .beer(beer), .state_display(state_display), .done(done), .fault(fault),
    .pour_count(pour_count)
  );

  multi_tap_draft #(
    .N_TAPS(SN), .LEVEL_W(LW), .BEER_LEVEL(2), .FOAM_TIMEOUT(4),
    .POUR_STEPS(1), .MAX_ACTIVE(SN)
  ) u_sat (
    .clk(clk), .reset(reset), .next(s_next), .draft(s_draft), .beer_level(s_level),
    .beer(s_beer), .state_display(s_sd), .done(s_done), .fault(s_fault),
    .pour_count(s_pc)
  );

  typedef struct {
    string          name;
    logic [2*N-1:0] sd;
    logic [N-1:0]   flt;
    logic [15:0]    pc;
  } exp_t;

  typedef struct {
    string         name;
    logic [SN-1:0] dn;
    logic [15:0]   pc;
  } sexp_t;

  exp_t  sb_q[$];
  sexp_t ssb_q[$];

  function automatic logic [7:0] sd4(logic [1:0] a, logic [1:0] b, logic [1:0] c, logic [1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [7:0] lv4(logic [1:0] a, logic [1:0] b, logic [1:0] c, logic [1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [N-1:0] dec(logic [2*N-1:0] sd, logic [1:0] code);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (sd[2*i +: 2] == code);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_m(string nm, logic [2*N-1:0] sd, logic [N-1:0] f, logic [15:0] pc);
    exp_t e;
    e.name = nm; e.sd = sd; e.flt = f; e.pc = pc;
    sb_q.push_back(e);
  endtask

  task automatic push_s(string nm, logic [SN-1:0] dn, logic [15:0] pc);
    sexp_t e;
    e.name = nm; e.dn = dn; e.pc = pc;
    ssb_q.push_back(e);
  endtask

  // Main monitor: the DUT presents a new result after every reset edge,
  // every step edge, and whenever the stimulus raises probe.
  initial begin
    logic prev;
    logic evt;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      evt  = reset || (next && !prev) || probe;
      prev = reset ? 1'b0 : next;
      if (evt) begin
        #1;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL main_unexpected: output event with empty scoreboard at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, ".state"}, 32'(state_display), 32'(e.sd));
          chk({e.name, ".beer"},  32'(beer),          32'(dec(e.sd, 2'd2)));
          chk({e.name, ".done"},  32'(done),          32'(dec(e.sd, 2'd3)));
          chk({e.name, ".fault"}, 32'(fault),         32'(e.flt));
          chk({e.name, ".pours"}, 32'(pour_count),    32'(e.pc));
        end
      end
    end
  end

  initial begin
    logic prev;
    logic evt;
    sexp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      evt  = reset || (s_next && !prev);
      prev = reset ? 1'b0 : s_next;
      if (evt) begin
        #1;
        if (ssb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sat_unexpected: output event with empty scoreboard at %0t", $time);
        end else begin
          e = ssb_q.pop_front();
          chk({e.name, ".done"},  32'(s_done), 32'(e.dn));
          chk({e.name, ".pours"}, 32'(s_pc),   32'(e.pc));
        end
      end
    end
  end

  task automatic step_m(string nm, logic [N-1:0] d, logic [N*LW-1:0] lv,
                        logic [2*N-1:0] esd, logic [N-1:0] ef, logic [15:0] epc);
    @(negedge clk);
    draft = d; beer_level = lv; next = 1'b1;
    push_m(nm, esd, ef, epc);
    @(negedge clk);
    next = 1'b0;
  endtask

  task automatic probe_m(string nm, logic [2*N-1:0] esd, logic [N-1:0] ef, logic [15:0] epc);
    @(negedge clk);
    probe = 1'b1;
    push_m(nm, esd, ef, epc);
    @(negedge clk);
    probe = 1'b0;
  endtask

  task automatic sat_step(string nm, logic [SN-1:0] d, logic [SN-1:0] edn, logic [15:0] epc);
    @(negedge clk);
    s_draft = d; s_next = 1'b1;
    push_s(nm, edn, epc);
    @(negedge clk);
    s_next = 1'b0;
  endtask

  // One full pour cycle for the taps in m: OFF->FOAM->BEER->DONE->OFF.
  task automatic sat_round(string nm, logic [SN-1:0] m, logic [15:0] pc0, logic [15:0] pc1);
    sat_step({nm, "_foam"}, m,  '0, pc0);
    sat_step({nm, "_beer"}, m,  '0, pc0);
    sat_step({nm, "_done"}, m,  m,  pc1);
    sat_step({nm, "_off"},  '0, '0, pc1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    push_m("reset", '0, '0, 16'd0);
    push_s("sat_reset", '0, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single tap full pour.
    step_m("s1_foam",  4'b0001, lv4(1,0,0,0), sd4(1,0,0,0), 4'b0000, 16'd0);
    step_m("s1_beer",  4'b0001, lv4(2,0,0,0), sd4(2,0,0,0), 4'b0000, 16'd0);
    step_m("s1_pour1", 4'b0001, lv4(2,0,0,0), sd4(2,0,0,0), 4'b0000, 16'd0);
    step_m("s1_pour2", 4'b0001, lv4(2,0,0,0), sd4(2,0,0,0), 4'b0000, 16'd0);
    step_m("s1_done",  4'b0001, lv4(2,0,0,0), sd4(3,0,0,0), 4'b0000, 16'd1);
    step_m("s1_off",   4'b0000, lv4(0,0,0,0), sd4(0,0,0,0), 4'b0000, 16'd1);

    // Foam timeout on tap 1; fault is sticky and the tap keeps working.
    step_m("s2_foam0", 4'b0010, lv4(0,1,0,0), sd4(0,1,0,0), 4'b0000, 16'd1);
    step_m("s2_foam1", 4'b0010, lv4(0,1,0,0), sd4(0,1,0,0), 4'b0000, 16'd1);
    step_m("s2_foam2", 4'b0010, lv4(0,1,0,0), sd4(0,1,0,0), 4'b0000, 16'd1);
    step_m("s2_foam3", 4'b0010, lv4(0,1,0,0), sd4(0,1,0,0), 4'b0000, 16'd1);
    step_m("s2_tmo",   4'b0010, lv4(0,1,0,0), sd4(0,0,0,0), 4'b0010, 16'd1);
    step_m("s2_refoam",4'b0010, lv4(0,1,0,0), sd4(0,1,0,0), 4'b0010, 16'd1);
    step_m("s2_off",   4'b0000, lv4(0,0,0,0), sd4(0,0,0,0), 4'b0010, 16'd1);

    // Three requesters, two slots; tap 2 gets in when tap 0 lets go.
    step_m("s3_foam",  4'b0111, lv4(2,2,2,0), sd4(1,1,1,0), 4'b0010, 16'd1);
    step_m("s3_grant", 4'b0111, lv4(2,2,2,0), sd4(2,2,1,0), 4'b0010, 16'd1);
    step_m("s3_hand",  4'b0110, lv4(2,2,2,0), sd4(1,2,2,0), 4'b0010, 16'd1);
    step_m("s3_t0off", 4'b0110, lv4(2,2,2,0), sd4(0,2,2,0), 4'b0010, 16'd1);
    step_m("s3_t1done",4'b0110, lv4(2,2,2,0), sd4(0,3,2,0), 4'b0010, 16'd2);
    step_m("s3_t2done",4'b0110, lv4(2,2,2,0), sd4(0,3,3,0), 4'b0010, 16'd3);
    step_m("s3_off",   4'b0000, lv4(0,0,0,0), sd4(0,0,0,0), 4'b0010, 16'd3);

    // next held high for 10 cycles gives a single step.
    @(negedge clk);
    draft = 4'b1000; beer_level = lv4(0,0,0,1); next = 1'b1;
    push_m("s4_hold", sd4(0,0,0,1), 4'b0010, 16'd3);
    repeat (10) @(negedge clk);
    next = 1'b0;
    probe_m("s4_once", sd4(0,0,0,1), 4'b0010, 16'd3);
    step_m("s4_beer", 4'b1000, lv4(0,0,0,2), sd4(0,0,0,2), 4'b0010, 16'd3);

    // Reset mid-BEER with a rising next in the same cycle, next held
    // through release: one step right after release.
    @(negedge clk);
    reset = 1'b1; next = 1'b1;
    push_m("s4_reset", '0, '0, 16'd0);
    push_s("sat_reset2", '0, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    push_m("s4_release", sd4(0,0,0,1), 4'b0000, 16'd0);
    repeat (3) @(negedge clk);
    next = 1'b0;
    probe_m("s4_rel_once", sd4(0,0,0,1), 4'b0000, 16'd0);
    step_m("s4_off", 4'b0000, lv4(0,0,0,0), sd4(0,0,0,0), 4'b0000, 16'd0);

    // Saturation: 8191 rounds of 8 pours = 65528, then 4 more = 65532.
    for (int r = 0; r < 8191; r++)
      sat_round("bulk", 8'hFF, 16'(8*r), 16'(8*r + 8));
    sat_round("sat_pre",  8'h0F, 16'd65528, 16'd65532);
    sat_round("sat_inc2", 8'h03, 16'd65532, 16'd65534);
    sat_round("sat_clip", 8'h0C, 16'd65534, 16'hFFFF);
    sat_round("sat_hold", 8'h30, 16'hFFFF,  16'hFFFF);

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0 || ssb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending main=%0d sat=%0d expected 0", sb_q.size(), ssb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
